// File: rtl/fp_peak_pkg.sv
// Shared definitions for the FP peak centroid responder: divider widths,
// fractional scale and FSM state encoding.
package fp_peak_pkg;
    localparam int FRAC_SCALE = 10000;
    localparam int DIV_W      = 40;
    localparam int DIVISOR_W  = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DIV1,
        S_DIV2,
        S_OUT
    } state_t;
endpackage

// File: rtl/fp_seq_div.sv
// Sequential restoring divider, one quotient bit per cycle. A start cycle
// loads the operands and done is raised on the cycle of the last iteration.
module fp_seq_div
    import fp_peak_pkg::*;
(
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 start,
    input  logic [DIV_W-1:0]     dividend,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [DIV_W-1:0]     quot,
    output logic [DIVISOR_W-1:0] rem
);
    logic [DIV_W-1:0]     num_r;
    logic [DIVISOR_W-1:0] den_r;
    logic [5:0]           iter_cnt;
    logic [DIVISOR_W:0]   trial;
    logic [DIVISOR_W:0]   diff;
    logic                 ge;

    assign trial = {rem, num_r[DIV_W-1]};
    assign diff  = trial - {1'b0, den_r};
    assign ge    = (trial >= {1'b0, den_r});
    assign done  = busy && (iter_cnt == 6'd1);

    // a start while busy restarts the divide; the caller relies on this after an abort
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            num_r    <= '0;
            den_r    <= '0;
            quot     <= '0;
            rem      <= '0;
            iter_cnt <= '0;
            busy     <= 1'b0;
        end else if (start) begin
            num_r    <= dividend;
            den_r    <= divisor;
            quot     <= '0;
            rem      <= '0;
            iter_cnt <= 6'(DIV_W);
            busy     <= 1'b1;
        end else if (busy) begin
            num_r    <= {num_r[DIV_W-2:0], 1'b0};
            quot     <= {quot[DIV_W-2:0], ge};
            rem      <= ge ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
            iter_cnt <= iter_cnt - 6'd1;
            if (iter_cnt == 6'd1)
                busy <= 1'b0;
        end
    end
endmodule

// File: rtl/fp_peak_centroid.sv
// Peak-fit responder: queues window requests, reads FIT_NUM samples and
// returns the intensity-weighted centroid as {frac/10000, int_addr}.
//
// state   | meaning
// S_IDLE  | wait for a queued request, pop it and clear accumulators
// S_READ  | issue FIT_NUM buffer reads
// S_DRAIN | accumulate the last returned sample
// S_DIV1  | sum_kw / sum_w -> integer offset and remainder
// S_DIV2  | rem*10000 / sum_w -> fractional part
// S_OUT   | register result and strobe peak_i_en
module fp_peak_centroid
    import fp_peak_pkg::*;
#(
    parameter int          FIT_NUM    = 21,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] BASELINE   = 16'd0
)(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        AD_start,
    input  logic        peak_fit_en,
    input  logic [15:0] fit_str_addr,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    input  logic [15:0] rd_data,
    output logic [31:0] peak_i,
    output logic        peak_i_en,
    output logic        busy,
    output logic        overflow,
    output logic        zero_win
);
    localparam int                PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [7:0]        RD_LAST   = 8'(FIT_NUM - 1);
    localparam logic [15:0]       MID_OFF   = 16'((FIT_NUM - 1) / 2);

    state_t               state;
    logic                 pfe_q;
    logic [15:0]          fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     fifo_cnt;
    logic                 req_edge, fifo_empty, fifo_full, push, pop;
    logic [15:0]          base, int_off, w;
    logic [7:0]           rd_cnt, k;
    logic                 rd_vld;
    logic [23:0]          sum_w;
    logic [31:0]          sum_kw;
    logic                 div_run, div_start, div_busy, div_done;
    logic [DIV_W-1:0]     div_dividend, div_quot;
    logic [DIVISOR_W-1:0] div_rem;
    logic [37:0]          rem_scaled;
    logic                 unused_div;

    assign req_edge   = peak_fit_en & ~pfe_q;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FIFO_FULL);
    assign pop        = (state == S_IDLE) && !fifo_empty && !AD_start;
    assign push       = req_edge && !AD_start && (!fifo_full || pop);
    assign busy       = (state != S_IDLE) || !fifo_empty;
    assign w          = (rd_data > BASELINE) ? rd_data - BASELINE : 16'd0;

    assign div_start    = ((state == S_DIV1) || (state == S_DIV2)) && !div_run;
    assign rem_scaled   = 38'(div_rem) * 38'(FRAC_SCALE);
    assign div_dividend = (state == S_DIV1) ? DIV_W'(sum_kw) : DIV_W'(rem_scaled);
    assign unused_div   = ^{div_busy, div_quot[DIV_W-1:16]};

    fp_seq_div u_div (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (sum_w),
        .busy      (div_busy),
        .done      (div_done),
        .quot      (div_quot),
        .rem       (div_rem)
    );

    always_ff @(posedge sys_clk) begin
        if (push)
            fifo_mem[wr_ptr] <= fit_str_addr;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pfe_q    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            pfe_q <= peak_fit_en;
            if (AD_start) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
                overflow <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
                fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
                if (req_edge && !push)
                    overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            rd_cnt    <= '0;
            rd_vld    <= 1'b0;
            base      <= '0;
            k         <= '0;
            sum_w     <= '0;
            sum_kw    <= '0;
            int_off   <= '0;
            div_run   <= 1'b0;
            peak_i    <= '0;
            peak_i_en <= 1'b0;
            zero_win  <= 1'b0;
        end else if (AD_start) begin
            state     <= S_IDLE;
            rd_en     <= 1'b0;
            rd_vld    <= 1'b0;
            k         <= '0;
            sum_w     <= '0;
            sum_kw    <= '0;
            div_run   <= 1'b0;
            peak_i    <= '0;
            peak_i_en <= 1'b0;
            zero_win  <= 1'b0;
        end else begin
            rd_vld    <= rd_en;
            peak_i_en <= 1'b0;
            zero_win  <= 1'b0;
            if (rd_vld) begin
                sum_w  <= sum_w + 24'(w);
                sum_kw <= sum_kw + 32'(k) * 32'(w);
                k      <= k + 8'd1;
            end
            if (div_start)
                div_run <= 1'b1;
            else if (div_done)
                div_run <= 1'b0;

            case (state)
                S_IDLE: if (pop) begin
                    base    <= fifo_mem[rd_ptr];
                    rd_addr <= fifo_mem[rd_ptr];
                    rd_en   <= 1'b1;
                    rd_cnt  <= RD_LAST;
                    k       <= '0;
                    sum_w   <= '0;
                    sum_kw  <= '0;
                    state   <= S_READ;
                end
                S_READ: if (rd_cnt == 8'd0) begin
                    rd_en <= 1'b0;
                    state <= S_DRAIN;
                end else begin
                    rd_addr <= rd_addr + 16'd1;
                    rd_cnt  <= rd_cnt - 8'd1;
                end
                S_DRAIN: state <= S_DIV1;
                S_DIV1: if (div_run && div_done) state <= S_DIV2;
                S_DIV2: begin
                    // first divide's quotient is final on the cycle the second one starts
                    if (div_start)
                        int_off <= div_quot[15:0];
                    if (div_run && div_done)
                        state <= S_OUT;
                end
                S_OUT: begin
                    peak_i_en <= 1'b1;
                    state     <= S_IDLE;
                    if (sum_w == 24'd0) begin
                        peak_i   <= {16'd0, base + MID_OFF};
                        zero_win <= 1'b1;
                    end else begin
                        peak_i <= {div_quot[15:0], base + int_off};
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_peak_centroid.sv
// Self-checking bench for fp_peak_centroid: vector table plus hand sequences
// for latency, overflow, abort and baseline handling.
module tb_fp_peak_centroid;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        AD_start = 1'b0;
    logic        pfe = 1'b0, pfe_b = 1'b0;
    logic [15:0] str_addr = '0, str_addr_b = '0;
    logic        rd_en, rd_en_b;
    logic [15:0] rd_addr, rd_addr_b;
    logic [15:0] rd_data = '0, rd_data_b = '0;
    logic [31:0] peak_i, peak_i_b;
    logic        peak_i_en, peak_i_en_b, busy, busy_b, overflow, overflow_b, zero_win, zero_win_b;

    logic [15:0] mem [0:65535];

    typedef struct { logic [31:0] peak; logic zero; } res_t;
    typedef struct {
        logic [15:0] base;
        int ka; logic [15:0] va;
        int kb; logic [15:0] vb;
        logic [31:0] peak; logic zero;
    } vec_t;

    res_t        sb[$];
    res_t        exp_r;
    logic [15:0] rd_log[$];
    int          total = 0, bad = 0, n_res = 0;

    fp_peak_centroid dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .AD_start(AD_start),
        .peak_fit_en(pfe), .fit_str_addr(str_addr),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .peak_i(peak_i), .peak_i_en(peak_i_en), .busy(busy),
        .overflow(overflow), .zero_win(zero_win)
    );

    fp_peak_centroid #(.BASELINE(16'd50)) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .AD_start(AD_start),
        .peak_fit_en(pfe_b), .fit_str_addr(str_addr_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .peak_i(peak_i_b), .peak_i_en(peak_i_en_b), .busy(busy_b),
        .overflow(overflow_b), .zero_win(zero_win_b)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (rd_en)   rd_data   <= mem[rd_addr];
        if (rd_en_b) rd_data_b <= mem[rd_addr_b];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    always @(posedge sys_clk) begin
        #1;
        if (rd_en) rd_log.push_back(rd_addr);
        if (peak_i_en) begin
            n_res++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got peak_i=%h, nothing expected", peak_i);
            end else begin
                exp_r = sb.pop_front();
                check("peak_i", 64'(peak_i), 64'(exp_r.peak));
                check("zero_win", 64'(zero_win), 64'(exp_r.zero));
            end
        end else if (zero_win) begin
            check("zero_win_without_en", 64'(zero_win), 64'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic req(input logic [15:0] a);
        tick();
        pfe = 1'b1;
        str_addr = a;
        tick();
        pfe = 1'b0;
    endtask

    task automatic set_win(input logic [15:0] b, input int ka, input logic [15:0] va,
                           input int kb, input logic [15:0] vb);
        for (int i = 0; i < 21; i++) mem[16'(int'(b) + i)] = 16'd0;
        if (va != 0) mem[16'(int'(b) + ka)] = va;
        if (vb != 0) mem[16'(int'(b) + kb)] = vb;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || sb.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        total++;
        if (n >= 3000) begin
            bad++;
            $display("FAIL idle_timeout: busy=%0d pending=%0d", busy, sb.size());
        end
    endtask

    function automatic res_t model(input logic [15:0] b, input int bl);
        longint sw, skw, q, rm;
        int v, wv;
        res_t r;
        sw = 0;
        skw = 0;
        for (int kk = 0; kk < 21; kk++) begin
            v  = int'(mem[16'(int'(b) + kk)]);
            wv = (v > bl) ? v - bl : 0;
            sw  += wv;
            skw += longint'(kk) * wv;
        end
        if (sw == 0) begin
            r.peak = {16'd0, 16'(int'(b) + 10)};
            r.zero = 1'b1;
        end else begin
            q  = skw / sw;
            rm = skw % sw;
            r.peak = {16'(rm * 10000 / sw), 16'(longint'(b) + q)};
            r.zero = 1'b0;
        end
        return r;
    endfunction

    initial begin
        vec_t vt[8];
        int cyc, n, ens, n0;
        res_t rr;
        logic [15:0] rb;

        vt[0] = '{16'd100,   10, 16'd1000,  0, 16'd0,     32'h0000_006E,         1'b0};
        vt[1] = '{16'd200,   10, 16'd100,  11, 16'd300,   {16'd7500, 16'd210},   1'b0};
        vt[2] = '{16'd200,    0, 16'd0,     0, 16'd0,     {16'd0, 16'd210},      1'b1};
        vt[3] = '{16'hFFFA,  15, 16'd7,     0, 16'd0,     {16'd0, 16'd9},        1'b0};
        vt[4] = '{16'd300,    0, 16'd1,    20, 16'd1,     {16'd0, 16'd310},      1'b0};
        vt[5] = '{16'd400,    3, 16'd3,     4, 16'd1,     {16'd2500, 16'd403},   1'b0};
        vt[6] = '{16'd500,    0, 16'd2,     1, 16'd1,     {16'd3333, 16'd500},   1'b0};
        vt[7] = '{16'd1000,  19, 16'd65535, 20, 16'd65535, {16'd5000, 16'd1019}, 1'b0};

        for (int i = 0; i < 65536; i++) mem[i] = 16'd0;

        tick();
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_peak_i", 64'(peak_i), 64'd0);
        check("rst_peak_i_en", 64'(peak_i_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_zero_win", 64'(zero_win), 64'd0);
        tick();
        sys_rst_n = 1'b1;
        tick();

        // single peak: latency and read address sequence
        set_win(16'd100, 10, 16'd1000, 0, 16'd0);
        sb.push_back('{32'h0000_006E, 1'b0});
        rd_log.delete();
        req(16'd100);
        check("busy_after_req", 64'(busy), 64'd1);
        cyc = 1;
        while (!peak_i_en && cyc < 300) begin
            tick();
            cyc++;
        end
        check("latency", 64'(cyc), 64'd107);
        check("rd_count", 64'(rd_log.size()), 64'd21);
        for (int i = 0; i < 21; i++)
            check("rd_addr_seq", 64'(rd_log[i]), 64'(100 + i));
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            set_win(vt[i].base, vt[i].ka, vt[i].va, vt[i].kb, vt[i].vb);
            sb.push_back('{vt[i].peak, vt[i].zero});
            req(vt[i].base);
            wait_idle();
        end

        // queued random windows, results in request order
        for (int j = 0; j < 3; j++) begin
            rb = 16'(5000 + 1000 * j);
            set_win(rb, 0, 16'd0, 0, 16'd0);
            for (int m = 0; m < 4; m++)
                mem[16'(int'(rb) + int'($urandom_range(0, 20)))] = 16'($urandom_range(0, 2000));
            sb.push_back(model(rb, 0));
        end
        for (int j = 0; j < 3; j++) req(16'(5000 + 1000 * j));
        wait_idle();

        // overflow: six pulses two cycles apart, sixth is dropped
        for (int j = 0; j < 6; j++)
            set_win(16'(2000 + 100 * j), j + 2, 16'd10, 0, 16'd0);
        for (int j = 0; j < 5; j++)
            sb.push_back('{{16'd0, 16'(2000 + 100 * j + j + 2)}, 1'b0});
        n0 = n_res;
        for (int j = 0; j < 5; j++) req(16'(2000 + 100 * j));
        check("overflow_before_6th", 64'(overflow), 64'd0);
        req(16'd2500);
        check("overflow_after_6th", 64'(overflow), 64'd1);
        wait_idle();
        check("overflow_result_count", 64'(n_res - n0), 64'd5);
        check("overflow_sticky", 64'(overflow), 64'd1);

        // abort during S_READ with requests queued
        n0 = n_res;
        for (int j = 0; j < 3; j++) begin
            set_win(16'(3000 + 100 * j), 5, 16'd9, 0, 16'd0);
            req(16'(3000 + 100 * j));
        end
        n = 0;
        while (!rd_en && n < 50) begin
            tick();
            n++;
        end
        check("abort_saw_read", 64'(rd_en), 64'd1);
        AD_start = 1'b1;
        tick();
        AD_start = 1'b0;
        check("abort_rd_en", 64'(rd_en), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_overflow", 64'(overflow), 64'd0);
        // AD_start together with a request edge drops the request
        tick();
        pfe = 1'b1;
        str_addr = 16'd3000;
        AD_start = 1'b1;
        tick();
        pfe = 1'b0;
        AD_start = 1'b0;
        check("abort_edge_busy", 64'(busy), 64'd0);
        ens = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (peak_i_en) ens++;
        end
        check("abort_no_result", 64'(ens), 64'd0);
        check("abort_result_count", 64'(n_res - n0), 64'd0);

        // recovery after abort
        set_win(16'd100, 10, 16'd1000, 0, 16'd0);
        sb.push_back('{32'h0000_006E, 1'b0});
        req(16'd100);
        wait_idle();

        // baseline 50 instance
        for (int i = 0; i < 21; i++) mem[i] = 16'd40;
        mem[9] = 16'd60;
        mem[10] = 16'd150;
        mem[11] = 16'd60;
        tick();
        pfe_b = 1'b1;
        str_addr_b = 16'd0;
        tick();
        pfe_b = 1'b0;
        n = 0;
        while (!peak_i_en_b && n < 300) begin
            tick();
            n++;
        end
        check("base_peak_i", 64'(peak_i_b), 64'({16'd0, 16'd10}));
        check("base_zero_win", 64'(zero_win_b), 64'd0);
        rr = model(16'd0, 50);
        check("base_model", 64'(peak_i_b), 64'(rr.peak));
        for (int i = 9; i < 12; i++) mem[i] = 16'd40;
        tick();
        pfe_b = 1'b1;
        str_addr_b = 16'd0;
        tick();
        pfe_b = 1'b0;
        n = 0;
        while (!peak_i_en_b && n < 300) begin
            tick();
            n++;
        end
        check("base_sat_peak_i", 64'(peak_i_b), 64'({16'd0, 16'd10}));
        check("base_sat_zero_win", 64'(zero_win_b), 64'd1);
        check("base_sat_en", 64'(peak_i_en_b), 64'd1);

        tick();
        check("final_pending", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
